// File: rtl/phase_counter_start_stop.sv
// Start/stop phase counter: synchronizes two async clocks, detects rising edges and measures
// clk_sample cycles from a clk_in_0 edge to the next clk_in_1 edge as a {clk0 count, phase} tag.
module phase_counter_start_stop #(
    parameter int unsigned phase_count_size = 12,
    parameter int unsigned clk_0_count_size = 4,
    parameter int unsigned sync_stages      = 2
) (
    input  logic                                         clk_sample,
    input  logic                                         rst,
    input  logic                                         clk_in_0,
    input  logic                                         clk_in_1,
    output logic [clk_0_count_size+phase_count_size-1:0] phase_tag,
    output logic                                         phase_tag_valid,
    output logic                                         overflow,
    output logic                                         missed_stop
);

    localparam int unsigned tag_width  = clk_0_count_size + phase_count_size;
    localparam int unsigned mask_width = $clog2(sync_stages + 2);
    localparam logic [mask_width-1:0] mask_len = mask_width'(sync_stages + 1);

    typedef enum logic [0:0] {StIdle, StCount} state_e;

    logic [sync_stages-1:0] sync0_q, sync1_q;
    logic                   dly0_q, dly1_q;
    logic                   rise0_q, rise1_q;
    logic [mask_width-1:0]  mask_cnt_q;
    logic                   mask_active;

    // Edges are suppressed until the synchronizer pipeline has flushed its reset zeros.
    assign mask_active = (mask_cnt_q != mask_len);

    always_ff @(posedge clk_sample) begin
        if (rst) begin
            sync0_q    <= '0;
            sync1_q    <= '0;
            dly0_q     <= 1'b0;
            dly1_q     <= 1'b0;
            rise0_q    <= 1'b0;
            rise1_q    <= 1'b0;
            mask_cnt_q <= '0;
        end else begin
            sync0_q    <= {sync0_q[sync_stages-2:0], clk_in_0};
            sync1_q    <= {sync1_q[sync_stages-2:0], clk_in_1};
            dly0_q     <= sync0_q[sync_stages-1];
            dly1_q     <= sync1_q[sync_stages-1];
            rise0_q    <= sync0_q[sync_stages-1] & ~dly0_q & ~mask_active;
            rise1_q    <= sync1_q[sync_stages-1] & ~dly1_q & ~mask_active;
            if (mask_active) begin
                mask_cnt_q <= mask_cnt_q + mask_width'(1);
            end
        end
    end

    state_e                        state_q, state_d;
    logic [phase_count_size-1:0]   phase_cnt_q, phase_cnt_d;
    logic [clk_0_count_size-1:0]   clk0_cnt_q, clk0_cnt_d, clk0_next;
    logic [clk_0_count_size-1:0]   start_id_q, start_id_d;
    logic [tag_width-1:0]          tag_q, tag_d;
    logic                          valid_q, valid_d;
    logic                          ovf_q, ovf_d;
    logic                          missed_q, missed_d;

    assign clk0_next = clk0_cnt_q + clk_0_count_size'(1);

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        start_id_d  = start_id_q;
        tag_d       = tag_q;
        valid_d     = 1'b0;
        ovf_d       = 1'b0;
        missed_d    = 1'b0;
        clk0_cnt_d  = rise0_q ? clk0_next : clk0_cnt_q;

        case (state_q)
            StIdle: begin
                if (rise0_q) begin
                    state_d     = StCount;
                    phase_cnt_d = phase_count_size'(1);
                    start_id_d  = clk0_next;
                end
            end
            StCount: begin
                if (rise1_q) begin
                    tag_d   = {start_id_q, phase_cnt_q};
                    valid_d = 1'b1;
                    if (rise0_q) begin
                        phase_cnt_d = phase_count_size'(1);
                        start_id_d  = clk0_next;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (rise0_q) begin
                    missed_d    = 1'b1;
                    phase_cnt_d = phase_count_size'(1);
                    start_id_d  = clk0_next;
                end else if (phase_cnt_q == '1) begin
                    tag_d   = {start_id_q, phase_cnt_q};
                    valid_d = 1'b1;
                    ovf_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    phase_cnt_d = phase_cnt_q + phase_count_size'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sample) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_cnt_q <= '0;
            clk0_cnt_q  <= '0;
            start_id_q  <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            missed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            clk0_cnt_q  <= clk0_cnt_d;
            start_id_q  <= start_id_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            missed_q    <= missed_d;
        end
    end

    assign phase_tag       = tag_q;
    assign phase_tag_valid = valid_q;
    assign overflow        = ovf_q;
    assign missed_stop     = missed_q;

endmodule

// File: tb/tb_phase_counter_start_stop.sv
// Scoreboard bench for phase_counter_start_stop: directed start/stop sequences push expected
// tags; a forked monitor pops and compares on every valid pulse.
module tb_phase_counter_start_stop;

    localparam int PW = 12;
    localparam int CW = 4;
    localparam int SS = 2;
    localparam int TW = PW + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in0;
    logic          in1;
    logic [TW-1:0] phase_tag;
    logic          phase_tag_valid;
    logic          overflow;
    logic          missed_stop;

    phase_counter_start_stop #(
        .phase_count_size(PW),
        .clk_0_count_size(CW),
        .sync_stages     (SS)
    ) dut (
        .clk_sample     (clk),
        .rst            (rst),
        .clk_in_0       (in0),
        .clk_in_1       (in1),
        .phase_tag      (phase_tag),
        .phase_tag_valid(phase_tag_valid),
        .overflow       (overflow),
        .missed_stop    (missed_stop)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [TW:0] exp_q[$];  // {overflow, tag}
    int n_checks   = 0;
    int n_errors   = 0;
    int missed_seen = 0;
    int missed_exp  = 0;
    int lat_start   = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [TW:0] e;
        forever begin
            @(negedge clk);
            if (phase_tag_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got tag %h, expected no tag", phase_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("tag", int'(phase_tag), int'(e[TW-1:0]));
                    check("overflow_with_tag", int'(overflow), int'(e[TW]));
                    if (lat_start >= 0) begin
                        check("valid_latency", cycle - lat_start, SS + 2);
                        lat_start = -1;
                    end
                end
            end else if (overflow) begin
                n_checks++;
                n_errors++;
                $display("FAIL overflow_without_valid: got 1, expected 0");
            end
            if (missed_stop) missed_seen++;
        end
    endtask

    task automatic push(input logic ovf, input logic [CW-1:0] id, input logic [PW-1:0] ph);
        exp_q.push_back({ovf, id, ph});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            wait_cyc(1);
            k++;
        end
        wait_cyc(10);
        check({name, "_pending_tags"}, exp_q.size(), 0);
        check({name, "_missed_stop"}, missed_seen, missed_exp);
        exp_q.delete();
        missed_seen = 0;
        missed_exp  = 0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // 1: inputs high through reset never produce an edge
        rst = 1'b1;
        in0 = 1'b1;
        in1 = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(50);
        check("t1_tag_zero", int'(phase_tag), 0);
        drain("t1");

        // 2: single measurement, phase 10, valid latency
        in0 = 1'b0;
        in1 = 1'b0;
        do_reset();
        wait_cyc(3);
        push(1'b0, 4'h1, 12'h00A);
        in0 = 1'b1;
        wait_cyc(10);
        in1 = 1'b1;
        lat_start = cycle;
        wait_cyc(3);
        in0 = 1'b0;
        in1 = 1'b0;
        drain("t2");

        // 3: 17 pairs, clk0 field wraps
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(1'b0, CW'((i + 1) % 16), 12'd5);
            in0 = 1'b1;
            wait_cyc(5);
            in1 = 1'b1;
            wait_cyc(2);
            in0 = 1'b0;
            in1 = 1'b0;
            wait_cyc(3);
        end
        drain("t3");

        // 4: saturation, then a late stop is ignored
        do_reset();
        push(1'b1, 4'h1, 12'hFFF);
        in0 = 1'b1;
        wait_cyc(4100);
        in1 = 1'b1;
        wait_cyc(10);
        in0 = 1'b0;
        in1 = 1'b0;
        drain("t4");

        // 5: second start restarts the measurement
        do_reset();
        missed_exp = 1;
        push(1'b0, 4'h2, 12'd7);
        in0 = 1'b1;
        wait_cyc(2);
        in0 = 1'b0;
        wait_cyc(18);
        in0 = 1'b1;
        wait_cyc(7);
        in1 = 1'b1;
        wait_cyc(2);
        in0 = 1'b0;
        in1 = 1'b0;
        drain("t5");

        // 6a: coincident start and stop
        do_reset();
        push(1'b0, 4'h1, 12'd6);
        push(1'b0, 4'h2, 12'd3);
        in0 = 1'b1;
        wait_cyc(2);
        in0 = 1'b0;
        wait_cyc(4);
        in0 = 1'b1;
        in1 = 1'b1;
        wait_cyc(1);
        in1 = 1'b0;
        wait_cyc(2);
        in1 = 1'b1;
        wait_cyc(2);
        in0 = 1'b0;
        in1 = 1'b0;
        drain("t6a");

        // 6b: reset mid-count discards the measurement
        do_reset();
        in0 = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(1);
        check("t6b_tag_after_rst", int'(phase_tag), 0);
        in1 = 1'b1;
        wait_cyc(10);
        in0 = 1'b0;
        in1 = 1'b0;
        drain("t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
